// File: rtl/medidor_periodo.sv
// medidor_periodo: measures period and high time of a slow square wave in
// system-clock cycles, one update per input period, with a loss-of-signal
// timeout.
//
// Output handshake: valid is a one-cycle strobe with no ready; period and
// high_time are stable from the edge that raises valid until the next valid.
module medidor_periodo #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,      // asynchronous, active-low
    input  logic         in_clk,     // asynchronous square wave
    output logic [W-1:0] period,
    output logic [W-1:0] high_time,
    output logic         valid,
    output logic         timeout,
    output logic         state_dbg   // 0 = IDLE, 1 = MEASURE
);

    typedef enum logic {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } state_t;

    state_t       state;
    state_t       state_nxt;

    logic         ff1;
    logic         s;
    logic         prev;
    logic         rise;
    logic         fall;

    logic [W-1:0] cnt;
    logic [W-1:0] hlat;
    logic         cnt_max;

    // FSM control strobes
    logic         load_cnt;
    logic         inc_cnt;
    logic         capture;
    logic         grab_high;
    logic         set_timeout;

    assign rise      = s & ~prev;
    assign fall      = ~s & prev;
    assign cnt_max   = (cnt == {W{1'b1}});
    assign state_dbg = state;

    // Two-flop synchronizer plus edge-detect history register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ff1  <= 1'b0;
            s    <= 1'b0;
            prev <= 1'b0;
        end else begin
            ff1  <= in_clk;
            s    <= ff1;
            prev <= s;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and control decode; rise and fall never coincide
    always_comb begin
        state_nxt   = state;
        load_cnt    = 1'b0;
        inc_cnt     = 1'b0;
        capture     = 1'b0;
        grab_high   = 1'b0;
        set_timeout = 1'b0;
        case (state)
            IDLE: begin
                // First rise only arms the measurement
                if (rise) begin
                    load_cnt  = 1'b1;
                    state_nxt = MEASURE;
                end
            end
            MEASURE: begin
                grab_high = fall;
                if (rise) begin
                    load_cnt = 1'b1;
                    capture  = 1'b1;
                end else if (cnt_max) begin
                    set_timeout = 1'b1;
                    state_nxt   = IDLE;
                end else begin
                    inc_cnt = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Cycle counter, high-time latch and registered results
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt       <= '0;
            hlat      <= '0;
            period    <= '0;
            high_time <= '0;
            valid     <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (load_cnt) begin
                cnt <= {{(W-1){1'b0}}, 1'b1};
            end else if (inc_cnt && !cnt_max) begin
                cnt <= cnt + 1'b1;
            end
            if (grab_high) begin
                hlat <= cnt;
            end
            if (capture) begin
                period    <= cnt;
                high_time <= hlat;
                valid     <= 1'b1;
                timeout   <= 1'b0;
            end
            if (set_timeout) begin
                timeout <= 1'b1;
            end
        end
    end

endmodule

// File: doc/medidor_periodo.md
# medidor_periodo

- Measures a slow clock-like square wave (e.g. a divided or delayed clock from our clock-generation blocks) against the system clock.
- Reports the wave's period and high time in system-clock cycles, one update per input period.
- Flags loss of the input signal with a timeout.
- Sits downstream of the clock generators as the self-check and monitoring end of the generated-clock path.

## Interface

Parameters:
- W, 16, width of the cycle counters and of the `period`/`high_time` outputs. Legal range 4..32.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- in_clk  input  1  square wave under measurement. Asynchronous to `clk`.
- period  output  W  last measured period, in clk cycles (rise to rise).
- high_time  output  W  last measured high time, in clk cycles (rise to fall).
- valid  output  1  one-cycle pulse when `period`/`high_time` update.
- timeout  output  1  sticky flag: no rising edge seen for 2^W-1 cycles.

## Operation

**Input conditioning**
- 2-flop synchronizer: ff1 → s.
- prev register holds the last s.
- rise = s & ~prev; fall = ~s & prev.

**FSM states**
- IDLE (reset state): waits for the first rise.
- MEASURE.

**Counter**
- cnt (W bits) loads 1 on the cycle rise is seen.
- Otherwise it increments each cycle while in MEASURE.
- It saturates at 2^W-1.
- Definition: k cycles after the rise-detect cycle, cnt = k.

**IDLE**
- rise → cnt<=1, go to MEASURE. No output update.

**MEASURE, fall**
- hlat<=cnt.

**MEASURE, rise**
- period<=cnt, high_time<=hlat, valid<=1, timeout<=0, cnt<=1.
- Stay in MEASURE.

**MEASURE, cnt == 2^W-1 without rise**
- timeout<=1, go to IDLE.
- period/high_time hold their last values; no valid pulse.

**General rules**
- rise and fall are mutually exclusive by construction, so no simultaneous-event priority is needed.
- The first rise after reset or after a timeout only arms the block; the first valid pulse comes on the second rise.
- The minimum measurable input phase is 1 clk cycle. Pulses shorter than a clk period may be missed, and no error is flagged.
- Arithmetic is unsigned, with no wrap: cnt saturates instead of overflowing.

**Reset (reset=0)**
- Asynchronous, at any time, including mid-period.
- Clears ff1, s, prev, cnt, hlat, period, high_time, valid, timeout to 0; state = IDLE.
- After release, the next rise re-arms the block.

## Timing

- Input latency: the clk edge that first samples in_clk=1 is edge N. s=1 after edge N+1, so rise is asserted during the N+1..N+2 cycle. Outputs and valid are registered at edge N+2 (2-cycle latency).
- valid is high for exactly one cycle per input period. period, high_time and timeout change only on the edge that sets valid, or on the timeout edge.
- For a stable input with H high and L low cycles (both ≥ 1): period = H+L and high_time = H on every valid pulse.
- timeout rises 2^W-1 cycles after the last rise-detect cycle.
- timeout stays high until the first valid pulse after re-arming: two rises after the signal returns.
- All outputs are 0 while reset=0 and for the first cycle after release.

## Test plan

1. reset=0 for 2 cycles, then 1; in_clk=0 → all outputs 0, state IDLE, no valid.
2. in_clk with H=5, L=5 → first valid on the second rise (+2 cycles). period=10 and high_time=5 on every subsequent valid, one pulse per 10 cycles.
3. in_clk with H=3, L=7, then switched to H=1, L=1 → period=10, high_time=3; then the first full period after the switch reports period=2, high_time=1.
4. W=8, in_clk running at H=L=4 then held at 0 → timeout=1 exactly 255 cycles after the last rise-detect. Outputs hold 8/4. After the input resumes, timeout clears on the second rise, with a valid pulse and period=8.
5. Assert reset=0 mid-period, 3 cycles after a rise, then release → outputs 0 at once (asynchronously). No valid on the first rise after release; correct values on the second rise.
6. W=4, period 20 cycles → timeout at cnt=15 and no valid ever. Then period 12 (H=6, L=6) → period=12, high_time=6.
